wbarb2: RTL and testbench
=========================

# wbarb2

Two-master to one-slave pipelined Wishbone arbiter. Lets two requesters (e.g. CPU instruction and data ports) share a single Wishbone slave such as a single-port RAM. Grants are round-robin and held for a whole bus cycle (`cyc`). Outstanding transactions are tracked so ownership only changes once every issued strobe has been acknowledged.

## Interface

Parameters:
- `MAXOUT`, default 4: maximum accepted-but-unacknowledged strobes per grant; range 1..15.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_ni`, input, 1: reset, synchronous, active-low.
- `bus0`, `if_wb.slave`, adr 32 / dat 32 / sel 4: requester 0; cyc, stb, we, sel, adr, write data in; read data, ack, stall out.
- `bus1`, `if_wb.slave`, same widths: requester 1.
- `mem`, `if_wb.master`, same widths: shared downstream slave.

## Operation

- State machine with three states: IDLE, GNT0, GNT1. Reset state is IDLE.
- `last` register records the previously granted master; reset value 1, so bus0 wins the first contention.
- **IDLE:**
  - Only bus0.cyc high -> GNT0.
  - Only bus1.cyc high -> GNT1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
- **GNTx, forwarding:**
  - mem.cyc = 1; mem.adr/we/sel/dat_o come from busx.
  - mem.stb = busx.stb & ~limit, where limit = (cnt == MAXOUT).
  - busx.stall = mem.stall | limit.
  - busx.ack = mem.ack; busx read data = mem read data.
- **Non-granted master:** stall = 1, ack = 0, read data = 0.
- **In IDLE:** both stall = 1; mem.cyc = mem.stb = mem.we = 0; mem.adr/sel/dat = 0.
- **Outstanding counter `cnt`:** width $clog2(MAXOUT+1).
  - +1 on accept (mem.stb & ~mem.stall); −1 on mem.ack.
  - Accept and ack in the same cycle: unchanged.
  - ack with cnt == 0: ignored, cnt stays 0; ack is still forwarded.
- **Release:** in GNTx, release when busx.cyc == 0 and the next cnt == 0.
  - On release, the next state is GNT(other) if the other cyc is high, else IDLE; `last` <= x.
- **cyc dropped early:** if busx drops cyc while cnt > 0:
  - stay in GNTx, with mem.stb forced to 0;
  - keep mem.cyc high and forward the remaining acks to busx;
  - release on the cycle cnt reaches 0.
- **Reset mid-operation:** rst_ni low at any edge -> IDLE, cnt = 0, `last` = 1. Pending acks after reset are not forwarded while in IDLE.
- The arbiter never creates or drops strobes. Each mem accept corresponds to exactly one busx accept in the same cycle.

## Timing

- Arbitration latency is 1 cycle: cyc sampled high in IDLE at edge N -> GNTx from edge N, so the first strobe can be accepted in cycle N+1.
- Forwarding in GNTx is combinational; zero added latency on stb, stall, ack and data.
- Hand-off latency: release seen at edge M -> other master granted from edge M, with no IDLE bubble.
- Throughput is one strobe per cycle while mem.stall = 0 and cnt < MAXOUT.
- Registered outputs: state, cnt, `last`. All other outputs are combinational from state and inputs.

## Test plan

- **Reset:** hold rst_ni = 0 for 3 cycles with both cyc = 1 -> both stall = 1, mem.cyc = 0; after release, GNT0 one cycle later.
- **Single master, 2-cycle-latency slave:** bus1 issues 4 reads back-to-back to 0x100–0x10C -> mem sees 4 consecutive accepts; bus1 receives 4 acks with matching data; bus0 stall = 1 throughout; IDLE after cyc drop.
- **Contention:** both cyc asserted together from reset -> bus0 served first. Bus1 is granted the cycle bus0's cyc drops with cnt = 0. Next contention after both release -> bus0 (round-robin alternates).
- **MAXOUT limit (MAXOUT = 2):** slave acks 5 cycles late; master issues 4 strobes -> bus stall asserted while cnt = 2; only 2 strobes in flight at any time; cnt returns to 0.
- **Early cyc drop:** bus0 drops cyc with cnt = 2 while bus1 requests -> GNT0 held until 2 acks are forwarded to bus0, then GNT1 with no gap; no strobe from bus1 reaches mem before then.
- **Mid-transfer reset:** rst_ni pulsed low for 1 cycle with cnt = 3 -> IDLE, cnt = 0, `last` = 1; late acks not forwarded; normal grant resumes.

Source files
------------

// File: rtl/wbarb2_if.sv
// Pipelined Wishbone bus bundle (32-bit address/data, 4 byte selects).
// The master side drives the request fields and the slave side returns
// read data, ack and stall.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, wdata,
    input  rdata, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, wdata,
    output rdata, ack, stall
  );
endinterface

// File: rtl/wbarb2.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Round-robin grant held for a whole bus cycle. Ownership only moves once
// every accepted strobe of the current owner has been acknowledged, so late
// acks always return to the master that issued them.
module wbarb2 #(
  parameter int MAXOUT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  if_wb.slave  bus0,
  if_wb.slave  bus1,
  if_wb.master mem
);

  localparam int CW = $clog2(MAXOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          limit;
  logic          accept;

  assign limit  = (cnt == CW'(MAXOUT));
  assign accept = mem.stb & ~mem.stall;

  // Steer the granted master onto mem; everything else sees stall and zero data.
  always_comb begin
    mem.cyc     = 1'b0;
    mem.stb     = 1'b0;
    mem.we      = 1'b0;
    mem.sel     = 4'h0;
    mem.adr     = 32'h0;
    mem.wdata   = 32'h0;
    bus0.stall  = 1'b1;
    bus0.ack    = 1'b0;
    bus0.rdata  = 32'h0;
    bus1.stall  = 1'b1;
    bus1.ack    = 1'b0;
    bus1.rdata  = 32'h0;
    case (state)
      GNT0: begin
        mem.cyc    = 1'b1;
        mem.stb    = bus0.cyc & bus0.stb & ~limit;
        mem.we     = bus0.we;
        mem.sel    = bus0.sel;
        mem.adr    = bus0.adr;
        mem.wdata  = bus0.wdata;
        bus0.stall = mem.stall | limit;
        bus0.ack   = mem.ack;
        bus0.rdata = mem.rdata;
      end
      GNT1: begin
        mem.cyc    = 1'b1;
        mem.stb    = bus1.cyc & bus1.stb & ~limit;
        mem.we     = bus1.we;
        mem.sel    = bus1.sel;
        mem.adr    = bus1.adr;
        mem.wdata  = bus1.wdata;
        bus1.stall = mem.stall | limit;
        bus1.ack   = mem.ack;
        bus1.rdata = mem.rdata;
      end
      default: begin
      end
    endcase
  end

  // Track accepted-but-unacknowledged strobes; a stray ack at zero is ignored.
  always_comb begin
    cnt_nxt = cnt;
    if (accept && !mem.ack) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!accept && mem.ack && (cnt != '0)) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Grant selection and release; hand-off goes straight to the other master.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (bus0.cyc && bus1.cyc) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (bus0.cyc) begin
          state_nxt = GNT0;
        end else if (bus1.cyc) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!bus0.cyc && (cnt_nxt == '0)) begin
          state_nxt = bus1.cyc ? GNT1 : IDLE;
          last_nxt  = 1'b0;
        end
      end
      GNT1: begin
        if (!bus1.cyc && (cnt_nxt == '0)) begin
          state_nxt = bus0.cyc ? GNT0 : IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, outstanding count and last-owner registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_wbarb2.sv
// Directed bench for wbarb2: one arbiter with MAXOUT=4 for grant/release,
// early-drop and reset scenarios, and a second with MAXOUT=2 behind a slow
// slave for the outstanding-limit scenario.
module tb_wbarb2;

  localparam logic [31:0] KEY  = 32'hA5A5_0000;
  localparam logic [31:0] WKEY = 32'h5555_5555;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  if_wb a0 ();
  if_wb a1 ();
  if_wb am ();
  if_wb b0 ();
  if_wb b1 ();
  if_wb bm ();

  wbarb2 #(.MAXOUT(4)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus0   (a0.slave),
    .bus1   (a1.slave),
    .mem    (am.master)
  );

  wbarb2 #(.MAXOUT(2)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus0   (b0.slave),
    .bus1   (b1.slave),
    .mem    (bm.master)
  );

  // Slave models: never stall unless told to, ack each accept lat cycles later
  // with read data derived from the address.
  logic [3:0]        lat_a = 4'd2;
  logic [3:0]        lat_b = 4'd5;
  logic              slv_stall_a = 1'b0;
  logic [15:0]       pv_a = '0;
  logic [15:0][31:0] pd_a = '0;
  logic [15:0]       pv_b = '0;
  logic [15:0][31:0] pd_b = '0;

  always @(posedge clk) begin
    pv_a <= {1'b0, pv_a[15:1]};
    pd_a <= {32'h0, pd_a[15:1]};
    if (am.cyc && am.stb && !am.stall) begin
      pv_a[lat_a - 4'd1] <= 1'b1;
      pd_a[lat_a - 4'd1] <= am.adr ^ KEY;
    end
  end

  always @(posedge clk) begin
    pv_b <= {1'b0, pv_b[15:1]};
    pd_b <= {32'h0, pd_b[15:1]};
    if (bm.cyc && bm.stb && !bm.stall) begin
      pv_b[lat_b - 4'd1] <= 1'b1;
      pd_b[lat_b - 4'd1] <= bm.adr ^ KEY;
    end
  end

  assign am.ack   = pv_a[0];
  assign am.rdata = pv_a[0] ? pd_a[0] : 32'h0;
  assign am.stall = slv_stall_a;
  assign bm.ack   = pv_b[0];
  assign bm.rdata = pv_b[0] ? pd_b[0] : 32'h0;
  assign bm.stall = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle values for the single-master run on arbiter A.
  int h_cyc [6] = '{1, 1, 1, 1, 1, 0};
  int h_stb [6] = '{1, 1, 1, 1, 0, 0};
  int h_ack [6] = '{0, 0, 1, 1, 1, 1};

  // Expected per-cycle values for the MAXOUT=2 run on arbiter B.
  int m_cyc   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int m_stb   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int m_idx   [14] = '{0, 1, 2, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0, 0};
  int m_stall [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
  int m_mstb  [14] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  int m_ack   [14] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
  int m_cnt   [14] = '{0, 1, 2, 2, 2, 2, 1, 1, 2, 2, 2, 2, 1, 0};

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and drive both requesters of arbiter A for the new cycle.
  task automatic applyStimulus(input logic c0, input logic s0, input logic w0, input logic [31:0] ad0,
                               input logic c1, input logic s1, input logic w1, input logic [31:0] ad1);
    @(posedge clk);
    #1;
    a0.cyc   = c0;
    a0.stb   = s0;
    a0.we    = w0;
    a0.adr   = ad0;
    a0.wdata = ad0 ^ WKEY;
    a0.sel   = 4'hF;
    a1.cyc   = c1;
    a1.stb   = s1;
    a1.we    = w1;
    a1.adr   = ad1;
    a1.wdata = ad1 ^ WKEY;
    a1.sel   = 4'h3;
    #1;
  endtask

  initial begin
    a0.cyc = 1'b1; a0.stb = 1'b0; a0.we = 1'b0; a0.sel = 4'hF; a0.adr = '0; a0.wdata = '0;
    a1.cyc = 1'b1; a1.stb = 1'b0; a1.we = 1'b0; a1.sel = 4'h3; a1.adr = '0; a1.wdata = '0;
    b0.cyc = 1'b0; b0.stb = 1'b0; b0.we = 1'b0; b0.sel = 4'hF; b0.adr = '0; b0.wdata = '0;
    b1.cyc = 1'b0; b1.stb = 1'b0; b1.we = 1'b0; b1.sel = 4'hF; b1.adr = '0; b1.wdata = '0;

    $display("[TB] reset held with both cyc high");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput("rst_stall0", 32'(a0.stall), 32'd1);
      checkOutput("rst_stall1", 32'(a1.stall), 32'd1);
      checkOutput("rst_mem_cyc", 32'(am.cyc), 32'd0);
    end
    rst_n = 1'b1;

    $display("[TB] contention from reset, bus0 first");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h200);
    checkOutput("g1_mem_cyc", 32'(am.cyc), 32'd1);
    checkOutput("g1_mem_stb", 32'(am.stb), 32'd1);
    checkOutput("g1_mem_adr", am.adr, 32'h000);
    checkOutput("g1_mem_sel", 32'(am.sel), 32'hF);
    checkOutput("g1_stall0", 32'(a0.stall), 32'd0);
    checkOutput("g1_stall1", 32'(a1.stall), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h004, 1'b1, 1'b0, 1'b0, 32'h200);
    checkOutput("g2_mem_adr", am.adr, 32'h004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h200);
    checkOutput("g3_ack0", 32'(a0.ack), 32'd1);
    checkOutput("g3_rdata0", a0.rdata, 32'h000 ^ KEY);
    checkOutput("g3_ack1", 32'(a1.ack), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h200);
    checkOutput("g4_ack0", 32'(a0.ack), 32'd1);
    checkOutput("g4_rdata0", a0.rdata, 32'h004 ^ KEY);
    checkOutput("g4_stall1", 32'(a1.stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h200);
    checkOutput("g5_stall1", 32'(a1.stall), 32'd0);
    checkOutput("g5_stall0", 32'(a0.stall), 32'd1);
    checkOutput("g5_mem_sel", 32'(am.sel), 32'h3);
    checkOutput("g5_mem_stb", 32'(am.stb), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);

    $display("[TB] bus0 alone, then contention goes to bus1");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("k1_mem_cyc", 32'(am.cyc), 32'd0);
    checkOutput("k1_mem_sel", 32'(am.sel), 32'h0);
    checkOutput("k1_stall0", 32'(a0.stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    slv_stall_a = 1'b1;
    #1;
    checkOutput("k2_mem_cyc", 32'(am.cyc), 32'd1);
    checkOutput("k2_stall_fwd0", 32'(a0.stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000);
    slv_stall_a = 1'b0;
    checkOutput("k3_last", 32'(dut_a.last), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("k4_stall1", 32'(a1.stall), 32'd0);
    checkOutput("k4_stall0", 32'(a0.stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("k5_mem_cyc", 32'(am.cyc), 32'd0);
    checkOutput("k5_last", 32'(dut_a.last), 32'd1);

    $display("[TB] bus1 four reads, two-cycle slave");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h100);
    checkOutput("i0_stall1", 32'(a1.stall), 32'd1);
    checkOutput("i0_mem_stb", 32'(am.stb), 32'd0);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, h_cyc[j] != 0, h_stb[j] != 0, 1'b0, 32'h100 + 32'(4 * j));
      checkOutput("h_mem_stb", 32'(am.stb), 32'(h_stb[j]));
      if (h_stb[j] != 0) checkOutput("h_mem_adr", am.adr, 32'h100 + 32'(4 * j));
      checkOutput("h_ack1", 32'(a1.ack), 32'(h_ack[j]));
      if (h_ack[j] != 0) checkOutput("h_rdata1", a1.rdata, (32'h100 + 32'(4 * (j - 2))) ^ KEY);
      checkOutput("h_stall0", 32'(a0.stall), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("h7_mem_cyc", 32'(am.cyc), 32'd0);

    $display("[TB] bus0 drops cyc with two writes in flight");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h300);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h040, 1'b1, 1'b1, 1'b0, 32'h300);
    checkOutput("e1_mem_stb", 32'(am.stb), 32'd1);
    checkOutput("e1_mem_we", 32'(am.we), 32'd1);
    checkOutput("e1_mem_wdata", am.wdata, 32'h040 ^ WKEY);
    checkOutput("e1_stall1", 32'(a1.stall), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h044, 1'b1, 1'b1, 1'b0, 32'h300);
    checkOutput("e2_mem_adr", am.adr, 32'h044);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h048, 1'b1, 1'b1, 1'b0, 32'h300);
    checkOutput("e3_cnt", 32'(dut_a.cnt), 32'd2);
    checkOutput("e3_mem_stb", 32'(am.stb), 32'd0);
    checkOutput("e3_mem_cyc", 32'(am.cyc), 32'd1);
    checkOutput("e3_ack0", 32'(a0.ack), 32'd1);
    checkOutput("e3_stall1", 32'(a1.stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h300);
    checkOutput("e4_ack0", 32'(a0.ack), 32'd1);
    checkOutput("e4_rdata0", a0.rdata, 32'h044 ^ KEY);
    checkOutput("e4_mem_stb", 32'(am.stb), 32'd0);
    checkOutput("e4_stall1", 32'(a1.stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h300);
    checkOutput("e5_mem_stb", 32'(am.stb), 32'd1);
    checkOutput("e5_mem_adr", am.adr, 32'h300);
    checkOutput("e5_mem_we", 32'(am.we), 32'd0);
    checkOutput("e5_stall1", 32'(a1.stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("e6_ack1", 32'(a1.ack), 32'd0);
    checkOutput("e6_mem_cyc", 32'(am.cyc), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("e7_ack1", 32'(a1.ack), 32'd1);
    checkOutput("e7_rdata1", a1.rdata, 32'h300 ^ KEY);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("e8_mem_cyc", 32'(am.cyc), 32'd0);

    $display("[TB] MAXOUT=2 with five-cycle slave");
    @(posedge clk);
    #1;
    b0.cyc = 1'b1;
    #1;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk);
      #1;
      b0.cyc = (m_cyc[j] != 0);
      b0.stb = (m_stb[j] != 0);
      b0.adr = 32'h600 + 32'(4 * m_idx[j]);
      #1;
      checkOutput("m_stall0", 32'(b0.stall), 32'(m_stall[j]));
      checkOutput("m_mem_stb", 32'(bm.stb), 32'(m_mstb[j]));
      checkOutput("m_ack0", 32'(b0.ack), 32'(m_ack[j]));
      checkOutput("m_cnt", 32'(dut_b.cnt), 32'(m_cnt[j]));
    end
    @(posedge clk);
    #2;
    checkOutput("m15_mem_cyc", 32'(bm.cyc), 32'd0);

    $display("[TB] reset pulse with three reads in flight");
    lat_a = 4'd6;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h500);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h504);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h508);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000);
    checkOutput("r4_cnt", 32'(dut_a.cnt), 32'd3);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    rst_n = 1'b1;
    checkOutput("r5_mem_cyc", 32'(am.cyc), 32'd0);
    checkOutput("r5_stall0", 32'(a0.stall), 32'd1);
    checkOutput("r5_stall1", 32'(a1.stall), 32'd1);
    checkOutput("r5_cnt", 32'(dut_a.cnt), 32'd0);
    checkOutput("r5_last", 32'(dut_a.last), 32'd1);
    for (int j = 6; j < 10; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
      checkOutput("r_late_ack1", 32'(a1.ack), 32'd0);
      checkOutput("r_late_ack0", 32'(a0.ack), 32'd0);
      checkOutput("r_late_rdata1", a1.rdata, 32'h0);
      if (j == 7) checkOutput("r7_slave_ack", 32'(am.ack), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000);
    checkOutput("r10_mem_cyc", 32'(am.cyc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("r11_stall0", 32'(a0.stall), 32'd0);
    checkOutput("r11_stall1", 32'(a1.stall), 32'd1);
    checkOutput("r11_mem_cyc", 32'(am.cyc), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000);
    checkOutput("r12_mem_cyc", 32'(am.cyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
